// File: rtl/bfm_link_1_1.sv
// bfm_link_1_1: point-to-point link model between a via output port and a
// downstream via input port. Accepts flits, drops those not addressed to
// NODE, buffers the rest with an arrival timestamp and presents each one
// downstream no earlier than LATENCY cycles after acceptance. Enqueued
// flits are checked for a consistent dst field and per-source counter
// continuity; any violation sets a sticky error flag.
//
// Optional feature: define BFM_LINK_STALL_EN to force in_ready_out low on
// every STALL_PERIOD-th cycle (cycle mod STALL_PERIOD == STALL_PERIOD-1).
module bfm_link_1_1 #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 1,
    parameter int DEPTH        = 4,
    parameter int LATENCY      = 2,
    parameter int STALL_PERIOD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_data_in,
    input  logic [N_ADDR_WIDTH-1:0] in_dest_in,
    input  logic                    in_valid_in,
    output logic                    in_ready_out,
    output logic [WIDTH-1:0]        out_data_out,
    output logic                    out_valid_out,
    input  logic                    out_ready_in,
    output logic                    err_out,
    output logic [15:0]             pkt_count_out,
    output logic [15:0]             drop_count_out
);

    localparam int A  = N_ADDR_WIDTH;
    localparam int C  = WIDTH - 2*A - 8;
    localparam int PW = $clog2(DEPTH);

    logic [15:0]      cycle;
    logic [15:0]      cycle_next;
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [15:0]      fifo_ts   [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      occ;
    logic [PW:0]      occ_next;
    logic             ready_next;

    logic [N-1:0]     seq_valid;
    logic [C-1:0]     seq_last [N];

    logic [A-1:0]     hdr_src;
    logic [A-1:0]     hdr_dst;
    logic [C-1:0]     hdr_cnt;
    logic             hdr_bad;
    logic             seq_bad;

    logic             accept;
    logic             for_me;
    logic             push;
    logic             drop;
    logic             xfer;
    logic [PW-1:0]    cand_ptr;
    logic             cand_avail;
    logic [15:0]      cand_age;
    logic             load;

    assign hdr_src = in_data_in[WIDTH-1 -: A];
    assign hdr_dst = in_data_in[WIDTH-1-A -: A];
    assign hdr_cnt = in_data_in[C-1:0];

    assign accept = in_valid_in & in_ready_out;
    assign for_me = (in_dest_in == A'(NODE));
    assign push   = accept & for_me;
    assign drop   = accept & ~for_me;
    assign xfer   = out_valid_out & out_ready_in;

    assign hdr_bad = (hdr_dst != in_dest_in);
    assign seq_bad = seq_valid[hdr_src] && (hdr_cnt != seq_last[hdr_src] + C'(1));

    // The presented flit stays in the FIFO until it transfers, so the
    // load candidate is the entry behind it when a transfer pops the head.
    assign cand_ptr   = xfer ? rd_ptr + PW'(1) : rd_ptr;
    assign cand_avail = xfer ? (occ > (PW+1)'(1)) : (occ != '0);
    assign cand_age   = cycle - fifo_ts[cand_ptr];
    assign load       = (~out_valid_out | xfer) & cand_avail & (cand_age >= 16'(LATENCY));

    assign cycle_next = cycle + 16'd1;

    // Occupancy after this edge's enqueue and dequeue, and the ready it implies.
    always_comb begin
        occ_next = occ;
        if (push && !xfer) begin
            occ_next = occ + (PW+1)'(1);
        end else if (!push && xfer) begin
            occ_next = occ - (PW+1)'(1);
        end
`ifdef BFM_LINK_STALL_EN
        ready_next = (occ_next < (PW+1)'(DEPTH)) &&
                     ((cycle_next % 16'(STALL_PERIOD)) != 16'(STALL_PERIOD - 1));
`else
        ready_next = (occ_next < (PW+1)'(DEPTH));
`endif
    end

    // Free-running cycle counter used for timestamps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle <= '0;
        end else begin
            cycle <= cycle_next;
        end
    end

    // FIFO storage; emptiness is tracked by the pointers, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= in_data_in;
            fifo_ts[wr_ptr]   <= cycle;
        end
    end

    // FIFO pointers, occupancy and registered ingress ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            in_ready_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ          <= occ_next;
            in_ready_out <= ready_next;
        end
    end

    // Egress register: load the next eligible head, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_out <= 1'b0;
            out_data_out  <= '0;
        end else if (load) begin
            out_valid_out <= 1'b1;
            out_data_out  <= fifo_data[cand_ptr];
        end else if (xfer) begin
            out_valid_out <= 1'b0;
        end
    end

    // Sequence table validity and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_valid <= '0;
            err_out   <= 1'b0;
        end else if (push) begin
            seq_valid[hdr_src] <= 1'b1;
            if (hdr_bad || seq_bad) begin
                err_out <= 1'b1;
            end
        end
    end

    // Last counter seen per source; only meaningful where seq_valid is set.
    always_ff @(posedge clk) begin
        if (push) begin
            seq_last[hdr_src] <= hdr_cnt;
        end
    end

    // Delivered and dropped flit counters, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count_out  <= '0;
            drop_count_out <= '0;
        end else begin
            if (xfer) begin
                pkt_count_out <= pkt_count_out + 16'd1;
            end
            if (drop) begin
                drop_count_out <= drop_count_out + 16'd1;
            end
        end
    end

endmodule

// File: doc/bfm_link_1_1.md
Name: bfm_link_1_1

Overview:
- Point-to-point link model that sits between a via's output port (data/dest/valid/ready) and a downstream via's input port (data/valid/ready).
- Terminates the sending side of the protocol: accepts flits, filters them by destination, and buffers them in a FIFO.
- Delivers each flit after a fixed link latency and checks the header and per-source sequence continuity.
- Lets the sink end of a via be exercised with realistic buffering, latency and backpressure.

Parameters:
- WIDTH, 32, flit width; header is {src[A], dst[A], id[8], counter[C]}.
- N, 16, number of nodes.
- N_ADDR_WIDTH, $clog2(N), address width A.
- NODE, 1, router index this link delivers to.
- DEPTH, 4, FIFO entries (power of 2, >=2).
- LATENCY, 2, cycles from accept to earliest out_valid_out (1..32767).
- STALL_PERIOD, 4, injected stall period (used only with the optional feature; >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_data_in  in  WIDTH  flit from upstream
- in_dest_in  in  N_ADDR_WIDTH  routing destination of flit
- in_valid_in  in  1  flit valid
- in_ready_out  out  1  link can accept
- out_data_out  out  WIDTH  flit to downstream sink
- out_valid_out  out  1  flit valid
- out_ready_in  in  1  sink accepts
- err_out  out  1  sticky header/sequence error
- pkt_count_out  out  16  flits delivered (wraps)
- drop_count_out  out  16  flits dropped by dest filter (wraps)

Behaviour:
- Widths: C = WIDTH-2*A-8. Fields: src = data[WIDTH-1 -: A], dst = next A bits, id = next 8 bits, counter = data[C-1:0].
- Reset (async, any time): FIFO emptied, in-flight flits discarded, cycle counter 0, sequence table invalid. Outputs: in_ready_out=0, out_valid_out=0, out_data_out=0, err_out=0, pkt_count_out=0, drop_count_out=0. First cycle after rst deasserts: in_ready_out=1.
- Accept: on posedge when in_valid_in && in_ready_out.
- in_ready_out is registered and equals (occupancy < DEPTH) after the edge's updates. No same-cycle bypass of a full FIFO.
- Dest filter: accepted flits with in_dest_in != NODE are consumed but not enqueued; drop_count_out increments.
- Enqueue: stores data and a 16-bit timestamp of the free-running cycle counter.
- Eligibility: the head entry is eligible when (cycle - ts) mod 2^16 >= LATENCY. A flit accepted at edge t drives out_valid_out=1 after edge t+LATENCY at the earliest.
- Egress:
  - out_valid_out and out_data_out are registered.
  - While out_valid_out && !out_ready_in, data is held stable.
  - Transfer on out_valid_out && out_ready_in. Next eligible head loads in the same edge, so back-to-back delivery is 1 flit/cycle.
  - pkt_count_out increments per transfer.
- Simultaneous enqueue and dequeue: occupancy unchanged. When full, an accept cannot occur that cycle, since in_ready_out was 0.
- Header check (on accept of an enqueued flit): err_out sets if dst field != in_dest_in.
- Sequence check (on accept of an enqueued flit):
  - Table of N entries {valid, last counter} indexed by src.
  - If valid and counter != last+1 mod 2^C, err_out sets.
  - The entry is then updated and marked valid.
- err_out stays set until reset.
- Counters wrap silently at 16 bits.

Optional Feature:
- Macro BFM_LINK_STALL_EN.
- Defined: every STALL_PERIOD-th cycle (cycle mod STALL_PERIOD == STALL_PERIOD-1), in_ready_out is forced 0 for that cycle, regardless of occupancy. Egress is unaffected.
- Undefined: in_ready_out depends on occupancy only, and STALL_PERIOD is ignored.

Test Plan:
- Reset then single flit {src=3,dst=1,id=5,cnt=7}, dest=1, accepted at edge 10, out_ready_in=1 -> out_valid_out rises after edge 12, data identical, pkt_count_out=1, err_out=0.
- out_ready_in=0, 5 flits to NODE with DEPTH=4 -> 4 accepted, in_ready_out=0. Then out_ready_in=1 -> 4 flits in order on consecutive cycles, then the 5th after its latency.
- Flit with dest=2 (NODE=1) -> no output, drop_count_out=1. Flit with dest=1 but dst field=2 -> delivered, err_out=1 and stays 1.
- src=3 counters 1,2,4 -> err_out rises on accept of 4. Separately, counter 2^C-1 followed by 0 -> err_out stays 0 (wrap).
- rst asserted asynchronously mid-cycle with 3 flits queued and out_valid_out=1 -> out_valid_out=0 and counts=0 immediately, nothing delivered afterwards.
- BFM_LINK_STALL_EN, STALL_PERIOD=4, in_valid_in held 1, out_ready_in=1 -> in_ready_out low on cycles 3,7,11..., 3 of 4 cycles accept.
